debug_unit_rx_ctrl: RTL and testbench
=====================================

# debug_unit_rx_ctrl

Parametrised receive-side controller of the MIPS debug unit, sitting between the UART receiver and the instruction memory and pipeline control. It decodes a byte-stream protocol and assembles multi-byte instruction words, writing them to consecutive instruction-memory addresses until the HALT word arrives. It then latches the execution mode and generates single-cycle step pulses. Over its predecessor it adds explicit write addressing, memory-full and inter-byte timeout error detection, and an abort command that returns to IDLE.

## Interface
- N_BITS, 8, UART byte width
- N_BITS_INSTR, 32, instruction width; must be an integer multiple of N_BITS
- N_BITS_ADDR, 8, instruction-memory address width (depth 2^N_BITS_ADDR words)
- N_TIMEOUT, 1000, idle cycles allowed between bytes of one partial word
- NB_STATE, 3, state encoding width
- i_clock  in  1  clock
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clock
- i_rx_data  in  N_BITS  received byte, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle byte strobe
- o_wr_en  out  1  one-cycle instruction-memory write strobe
- o_wr_addr  out  N_BITS_ADDR  write address
- o_wr_data  out  N_BITS_INSTR  assembled word; zero when o_wr_en=0
- o_load_done  out  1  level: HALT written, program loaded
- o_execution_mode  out  1  level: 1 = step mode, 0 = continuous
- o_execution_step  out  1  one-cycle step pulse
- o_error  out  1  sticky: timeout or memory full
- o_state  out  NB_STATE  current FSM state

## Operation
- States: IDLE=0, LOAD=1, MODE_SEL=2, RUN=3, ERROR=4.
- IDLE: byte 0x55 (CMD_LOAD) -> LOAD, with address counter, byte counter and o_load_done cleared. All other bytes are ignored.
- LOAD: bytes are shifted in MSB-first. After BPI = N_BITS_INSTR/N_BITS bytes:
  - o_wr_en pulses with o_wr_addr = addr counter and o_wr_data = word.
  - The addr counter increments and the byte counter returns to 0.
  - Every byte in LOAD is data; 0xAA is not decoded there.
- In LOAD, a word equal to all-ones (HALT) is still written, then o_load_done=1 and the FSM goes to MODE_SEL.
- A non-HALT word written at address 2^N_BITS_ADDR-1 -> ERROR. The address never wraps.
- Timeout: while the byte counter is nonzero, a counter runs on cycles without i_rx_done. When it reaches N_TIMEOUT, the partial word is discarded and the FSM goes to ERROR. Each byte reloads the counter to 0.
- MODE_SEL: bytes 0xFF (HALT trailing bytes) are ignored. Any other byte latches o_execution_mode = bit0 and moves to RUN.
- RUN:
  - Byte 0xAA (CMD_ABORT) -> IDLE and clears o_execution_mode and o_load_done.
  - Otherwise, in step mode, a byte with bit0=1 produces one o_execution_step pulse.
  - In continuous mode, non-abort bytes are ignored.
- ERROR: o_error=1. Byte 0xAA -> IDLE and clears o_error. Other bytes are ignored.
- Reset: state IDLE. All outputs are 0; counters and the shift register are 0.

## Timing
- Each byte is consumed on the edge where i_rx_done=1. State and outputs are registered, so every response appears the cycle after the strobe.
- o_wr_en, o_wr_addr and o_wr_data are valid together for exactly one cycle, one cycle after the final byte strobe of a word.
- o_execution_step is high for exactly one cycle per qualifying byte. Back-to-back strobes give back-to-back pulses.
- Simultaneous events:
  - A byte strobe in the cycle the timeout would fire wins: the byte is accepted and the timer is cleared.
  - The HALT check takes precedence over the memory-full check on the same word.
- Reset mid-word or mid-RUN: the next cycle is IDLE with all outputs 0. There is no write of the partial word.

## Structure
- Package debug_unit_pkg holds:
  - state encodings
  - CMD_LOAD=0x55 and CMD_ABORT=0xAA
  - HALT_INSTRUCTION (all ones, width N_BITS_INSTR)
- Sub-module debug_unit_word_assembler contains the shift register, byte counter, word-complete strobe and timeout counter. It exposes a clear input.
- The FSM, address counter and output registers live in the top module.

## Test plan
- Load 0x55, then 0x20,0x01,0x00,0x0A, then 0xFF×4 (N_BITS_INSTR=32) -> writes 0x2001000A@0 and 0xFFFFFFFF@1; o_load_done=1; state MODE_SEL.
- Next byte 0x01, then bytes 0x01,0x00,0x01 -> o_execution_mode=1 and exactly two single-cycle o_execution_step pulses.
- Mode byte 0x00, then 0x01 -> no step pulse. Then 0xAA -> state IDLE; o_execution_mode=0; o_load_done=0.
- 0x55 followed by 2 bytes, then N_TIMEOUT idle cycles -> o_error=1, state ERROR, no write. Then 0xAA -> IDLE with o_error=0.
- N_BITS_ADDR=2: 4 non-HALT words -> writes @0..3, then ERROR. A 5th word produces no write.
- Reset asserted after the 3rd byte of a word -> next cycle all outputs 0; a fresh load writes at address 0.

Source files
------------

// File: rtl/debug_unit_pkg.sv
// Shared definitions for the debug unit receive path: FSM state encoding,
// protocol command bytes and the HALT instruction pattern.
package debug_unit_pkg;

  // Receive controller states; values are visible on o_state for debug.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_MODE_SEL = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

  // Protocol command bytes.
  localparam logic [7:0] CMD_LOAD  = 8'h55;
  localparam logic [7:0] CMD_ABORT = 8'hAA;

  // HALT is the all-ones instruction; users slice the low N_BITS_INSTR bits,
  // so instruction widths up to MAX_INSTR_BITS are supported.
  localparam int MAX_INSTR_BITS = 128;
  localparam logic [MAX_INSTR_BITS-1:0] HALT_INSTRUCTION = '1;

endpackage

// File: rtl/debug_unit_word_assembler.sv
// Packs UART bytes MSB-first into instruction words. Flags the byte that
// completes a word and the expiry of the inter-byte timeout on a partial word.
// clear_i drops any partial word and resets the timer.
module debug_unit_word_assembler
  import debug_unit_pkg::*;
#(
  parameter int N_BITS       = 8,
  parameter int N_BITS_INSTR = 32,
  parameter int N_TIMEOUT    = 1000
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    clear_i,
  input  logic                    byte_valid_i,
  input  logic [N_BITS-1:0]       byte_i,
  output logic [N_BITS_INSTR-1:0] word_o,
  output logic                    word_done_o,
  output logic                    timeout_o
);

  localparam int BPI   = N_BITS_INSTR / N_BITS;
  localparam int CNT_W = (BPI > 1) ? $clog2(BPI) : 1;
  localparam int TMR_W = $clog2(N_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPI - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(N_TIMEOUT - 1);

  logic [N_BITS_INSTR-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [N_BITS_INSTR-1:0] shifted;

  // Word as it would look with the current byte appended at the LSB end.
  assign shifted = (shift_q << N_BITS) | N_BITS_INSTR'(byte_i);
  assign word_o  = shifted;

  // Next-state logic: clear wins, then a byte, then idle-cycle timing.
  // A byte in the cycle the timer would expire is accepted and resets it.
  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    word_done_o = 1'b0;
    timeout_o   = 1'b0;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
      tmr_d   = '0;
    end else if (byte_valid_i) begin
      tmr_d = '0;
      if (cnt_q == LAST_CNT) begin
        word_done_o = 1'b1;
        shift_d     = '0;
        cnt_d       = '0;
      end else begin
        shift_d = shifted;
        cnt_d   = cnt_q + 1'b1;
      end
    end else if (cnt_q != '0) begin
      if (tmr_q == TMR_LAST) begin
        timeout_o = 1'b1;
        shift_d   = '0;
        cnt_d     = '0;
        tmr_d     = '0;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  // Register the shift register, byte counter and timeout counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

endmodule

// File: rtl/debug_unit_rx_ctrl.sv
// Receive-side controller of the MIPS debug unit: decodes the UART byte
// protocol, writes assembled words to consecutive instruction-memory
// addresses until HALT, then latches the execution mode and issues steps.
//
// Input handshake: i_rx_done is a one-cycle strobe with no back-pressure;
// i_rx_data is consumed on the rising edge where i_rx_done=1 and every
// response is registered, appearing the following cycle.
module debug_unit_rx_ctrl
  import debug_unit_pkg::*;
#(
  parameter int N_BITS       = 8,
  parameter int N_BITS_INSTR = 32,
  parameter int N_BITS_ADDR  = 8,
  parameter int N_TIMEOUT    = 1000,
  parameter int NB_STATE     = 3
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [N_BITS-1:0]       i_rx_data,
  input  logic                    i_rx_done,
  output logic                    o_wr_en,
  output logic [N_BITS_ADDR-1:0]  o_wr_addr,
  output logic [N_BITS_INSTR-1:0] o_wr_data,
  output logic                    o_load_done,
  output logic                    o_execution_mode,
  output logic                    o_execution_step,
  output logic                    o_error,
  output logic [NB_STATE-1:0]     o_state
);

  localparam logic [N_BITS_ADDR-1:0]  ADDR_MAX  = '1;
  localparam logic [N_BITS-1:0]       BYTE_ONES = '1;
  localparam logic [N_BITS-1:0]       LOAD_B    = N_BITS'(CMD_LOAD);
  localparam logic [N_BITS-1:0]       ABORT_B   = N_BITS'(CMD_ABORT);
  localparam logic [N_BITS_INSTR-1:0] HALT_W    = HALT_INSTRUCTION[N_BITS_INSTR-1:0];

  state_e                  state_q, state_d;
  logic [N_BITS_ADDR-1:0]  addr_q, addr_d;
  logic                    wr_en_q, wr_en_d;
  logic [N_BITS_ADDR-1:0]  wr_addr_q, wr_addr_d;
  logic [N_BITS_INSTR-1:0] wr_data_q, wr_data_d;
  logic                    load_done_q, load_done_d;
  logic                    mode_q, mode_d;
  logic                    step_q, step_d;
  logic                    error_q, error_d;

  logic                    asm_clear;
  logic                    asm_valid;
  logic [N_BITS_INSTR-1:0] asm_word;
  logic                    asm_done;
  logic                    asm_timeout;

  // Only LOAD feeds the assembler; everywhere else it is held empty so a
  // new load always starts from byte 0.
  assign asm_clear = (state_q != ST_LOAD);
  assign asm_valid = i_rx_done && (state_q == ST_LOAD);

  debug_unit_word_assembler #(
    .N_BITS       (N_BITS),
    .N_BITS_INSTR (N_BITS_INSTR),
    .N_TIMEOUT    (N_TIMEOUT)
  ) u_word_assembler (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_i       (i_rx_data),
    .word_o       (asm_word),
    .word_done_o  (asm_done),
    .timeout_o    (asm_timeout)
  );

  // Next-state and output decode; pulses default low, levels hold.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    load_done_d = load_done_q;
    mode_d      = mode_q;
    step_d      = 1'b0;
    error_d     = error_q;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_done && (i_rx_data == LOAD_B)) begin
          state_d     = ST_LOAD;
          addr_d      = '0;
          load_done_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (asm_timeout) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else if (asm_done) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = asm_word;
          // HALT is checked first so a HALT in the last slot still loads.
          if (asm_word == HALT_W) begin
            load_done_d = 1'b1;
            state_d     = ST_MODE_SEL;
          end else if (addr_q == ADDR_MAX) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
          // The address saturates instead of wrapping.
          if (addr_q != ADDR_MAX) begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_MODE_SEL: begin
        // All-ones bytes are trailing HALT padding and are skipped.
        if (i_rx_done && (i_rx_data != BYTE_ONES)) begin
          mode_d  = i_rx_data[0];
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_rx_done) begin
          if (i_rx_data == ABORT_B) begin
            state_d     = ST_IDLE;
            mode_d      = 1'b0;
            load_done_d = 1'b0;
          end else if (mode_q && i_rx_data[0]) begin
            step_d = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        if (i_rx_done && (i_rx_data == ABORT_B)) begin
          state_d = ST_IDLE;
          error_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      load_done_q <= 1'b0;
      mode_q      <= 1'b0;
      step_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      load_done_q <= load_done_d;
      mode_q      <= mode_d;
      step_q      <= step_d;
      error_q     <= error_d;
    end
  end

  assign o_wr_en          = wr_en_q;
  assign o_wr_addr        = wr_addr_q;
  assign o_wr_data        = wr_data_q;
  assign o_load_done      = load_done_q;
  assign o_execution_mode = mode_q;
  assign o_execution_step = step_q;
  assign o_error          = error_q;
  assign o_state          = NB_STATE'(state_q);

endmodule

// File: tb/tb_debug_unit_rx_ctrl.sv
// Bench for debug_unit_rx_ctrl: directed protocol scenarios followed by
// random byte traffic, checked against a byte-level protocol model.
module tb_debug_unit_rx_ctrl;

  localparam int NB    = 8;
  localparam int INSTR = 32;
  localparam int ADDR  = 2;
  localparam int TMO   = 20;
  localparam int BPI   = INSTR / NB;
  localparam int DEPTH = 1 << ADDR;

  localparam int M_IDLE = 0, M_LOAD = 1, M_MODE_SEL = 2, M_RUN = 3, M_ERROR = 4;

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              i_reset;
  logic [NB-1:0]     i_rx_data;
  logic              i_rx_done;
  logic              o_wr_en;
  logic [ADDR-1:0]   o_wr_addr;
  logic [INSTR-1:0]  o_wr_data;
  logic              o_load_done;
  logic              o_execution_mode;
  logic              o_execution_step;
  logic              o_error;
  logic [2:0]        o_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  debug_unit_rx_ctrl #(
    .N_BITS       (NB),
    .N_BITS_INSTR (INSTR),
    .N_BITS_ADDR  (ADDR),
    .N_TIMEOUT    (TMO),
    .NB_STATE     (3)
  ) dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .i_rx_data        (i_rx_data),
    .i_rx_done        (i_rx_done),
    .o_wr_en          (o_wr_en),
    .o_wr_addr        (o_wr_addr),
    .o_wr_data        (o_wr_data),
    .o_load_done      (o_load_done),
    .o_execution_mode (o_execution_mode),
    .o_execution_step (o_execution_step),
    .o_error          (o_error),
    .o_state          (o_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int mon_cyc  = 0;
  logic [ADDR+INSTR-1:0] exp_q[$];
  int                    step_q[$];

  task automatic report(input bit ok, input string name,
                        input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_state;
  int          m_addr;
  bit          m_load_done, m_mode, m_error;
  logic [7:0]  m_bytes[$];
  int          m_idle;

  task automatic model_reset();
    m_state = M_IDLE; m_addr = 0; m_load_done = 0; m_mode = 0; m_error = 0;
    m_bytes.delete(); m_idle = 0;
    exp_q.delete(); step_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] word;
    case (m_state)
      M_IDLE: if (b == 8'h55) begin
        m_state = M_LOAD; m_addr = 0; m_load_done = 0; m_bytes.delete(); m_idle = 0;
      end
      M_LOAD: begin
        m_bytes.push_back(b);
        m_idle = 0;
        if (m_bytes.size() == BPI) begin
          word = 0;
          foreach (m_bytes[i]) word = (word << 8) | 32'(m_bytes[i]);
          m_bytes.delete();
          exp_q.push_back({ADDR'(m_addr), word});
          if (word == 32'hFFFF_FFFF) begin
            m_load_done = 1; m_state = M_MODE_SEL;
          end else if (m_addr == DEPTH - 1) begin
            m_state = M_ERROR; m_error = 1;
          end else begin
            m_addr++;
          end
        end
      end
      M_MODE_SEL: if (b != 8'hFF) begin m_mode = b[0]; m_state = M_RUN; end
      M_RUN: begin
        if (b == 8'hAA) begin m_state = M_IDLE; m_mode = 0; m_load_done = 0; end
        else if (m_mode && b[0]) step_q.push_back(mon_cyc + 1);
      end
      M_ERROR: if (b == 8'hAA) begin m_state = M_IDLE; m_error = 0; end
      default: ;
    endcase
  endtask

  task automatic model_idle();
    if (m_state == M_LOAD && m_bytes.size() > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_bytes.delete(); m_state = M_ERROR; m_error = 1; m_idle = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Every driver returns at a falling edge, so outputs are stable there.
  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge clk);
    model_byte(b);
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      model_idle();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = BPI - 1; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic check_levels(input string tag);
    report(o_state == 3'(m_state), {tag, "_state"}, 64'(o_state), 64'(m_state));
    report(o_load_done == m_load_done, {tag, "_load_done"}, 64'(o_load_done), 64'(m_load_done));
    report(o_execution_mode == m_mode, {tag, "_mode"}, 64'(o_execution_mode), 64'(m_mode));
    report(o_error == m_error, {tag, "_error"}, 64'(o_error), 64'(m_error));
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [ADDR+INSTR-1:0] exp;
    bit                    step_due;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (o_wr_en) begin
        if (exp_q.size() == 0) begin
          report(1'b0, "unexpected_write", {o_wr_addr, o_wr_data}, 64'(0));
        end else begin
          exp = exp_q.pop_front();
          report({o_wr_addr, o_wr_data} == exp, "write", {o_wr_addr, o_wr_data}, 64'(exp));
        end
      end else if (o_wr_data != '0) begin
        report(1'b0, "wr_data_idle_zero", 64'(o_wr_data), 64'(0));
      end
      step_due = (step_q.size() > 0) && (step_q[0] == mon_cyc);
      if (step_due || o_execution_step) begin
        report(o_execution_step == step_due, "step_pulse", 64'(o_execution_step), 64'(step_due));
        if (step_due) void'(step_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  b;
    logic [31:0] w;
    i_reset   = 1'b1;
    i_rx_data = '0;
    i_rx_done = 1'b0;
    @(negedge clk);
    do_reset();
    check_levels("reset");
    report(o_state == 3'd0, "reset_state_idle", 64'(o_state), 64'(0));

    // Program load: one instruction then HALT, then step mode.
    send_byte(8'h55);
    check_levels("cmd_load");
    send_word(32'h2001_000A);
    send_word(32'hFFFF_FFFF);
    check_levels("loaded");
    report(o_load_done == 1'b1 && o_state == 3'd2, "load_done_mode_sel",
           {o_load_done, o_state}, {1'b1, 3'd2});
    send_byte(8'h01);
    check_levels("step_mode");
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    check_levels("steps");

    // Continuous mode: no step pulse, then abort.
    send_byte(8'hAA);
    send_byte(8'h55);
    send_word(32'hFFFF_FFFF);
    send_byte(8'h00);
    send_byte(8'h01);
    check_levels("continuous");
    send_byte(8'hAA);
    check_levels("abort_run");

    // Timeout on a partial word, checked one cycle early and on expiry.
    send_byte(8'h55);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(TMO - 1);
    check_levels("pre_timeout");
    idle(1);
    check_levels("timeout");
    report(o_error == 1'b1 && o_state == 3'd4, "timeout_error", {o_error, o_state}, {1'b1, 3'd4});
    send_byte(8'h13);
    check_levels("error_ignore");
    send_byte(8'hAA);
    check_levels("abort_error");

    // A byte arriving exactly when the timer would expire is accepted.
    send_byte(8'h55);
    send_byte(8'hDE);
    idle(TMO - 1);
    send_byte(8'hAD);
    check_levels("race_byte_wins");
    idle(TMO - 1);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_word(32'hFFFF_FFFF);
    check_levels("race_done");
    send_byte(8'hAA);
    send_byte(8'hAA);

    // Memory full: four non-HALT words fill the memory, a fifth is ignored.
    send_byte(8'h55);
    for (int i = 0; i < DEPTH; i++) send_word(32'h1000_0000 + 32'(i));
    check_levels("mem_full");
    send_word(32'h0102_0304);
    check_levels("mem_full_ignored");
    send_byte(8'hAA);

    // Reset in the middle of a word; a fresh load starts at address 0.
    send_byte(8'h55);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    do_reset();
    check_levels("mid_reset");
    report({o_wr_en, o_execution_step, o_wr_addr, o_wr_data} == '0, "mid_reset_outputs",
           {o_wr_en, o_execution_step, o_wr_addr, o_wr_data}, 64'(0));
    send_byte(8'h55);
    send_word(32'hCAFE_0001);
    send_word(32'hFFFF_FFFF);
    check_levels("reload");
    send_byte(8'h01);
    send_byte(8'hAA);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'h55;
        2:       b = 8'hAA;
        3:       b = 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom();
        if ($urandom_range(0, 2) == 0) w = 32'hFFFF_FFFF;
        send_word(w);
      end else begin
        send_byte(b);
      end
      check_levels("rand");
      if ($urandom_range(0, 15) == 0) begin
        idle($urandom_range(1, TMO + 3));
        check_levels("rand_idle");
      end
    end

    idle(3);
    report(exp_q.size() == 0, "writes_outstanding", 64'(exp_q.size()), 64'(0));
    report(step_q.size() == 0, "steps_outstanding", 64'(step_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
